// File: rtl/rgb_axis_pkg.sv
// rtl/rgb_axis_pkg.sv - shared widths, FIFO word layout and FSM state codes
package rgb_axis_pkg;

   localparam int RGB_W     = 24;
   localparam int WORD_W    = RGB_W + 2;
   localparam int TLAST_BIT = RGB_W;
   localparam int TUSER_BIT = RGB_W + 1;

   localparam logic [1:0] ST_WAIT_SOF = 2'd0;
   localparam logic [1:0] ST_ACTIVE   = 2'd1;
   localparam logic [1:0] ST_DROP     = 2'd2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO
module sync_fifo_fwft #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_wr, do_rd;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   always_comb begin
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/rgb_stream_to_axis.sv
// rtl/rgb_stream_to_axis.sv - pixel-clock RGB stream to AXI4-Stream video with overflow drop and geometry check
module rgb_stream_to_axis
   import rgb_axis_pkg::*;
#(
   parameter int   H_ACTIVE   = 1280,
   parameter int   V_ACTIVE   = 720,
   parameter int   FIFO_DEPTH = 1024,
   parameter logic VSYNC_POL  = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [RGB_W-1:0]              i_rgb_data,
   input  logic                          i_rgb_hsync,
   input  logic                          i_rgb_vsync,
   input  logic                          i_rgb_vde,
   input  logic [10:0]                   i_set_x,
   input  logic [9:0]                    i_set_y,
   output logic [RGB_W-1:0]              o_axis_tdata,
   output logic                          o_axis_tuser,
   output logic                          o_axis_tlast,
   output logic                          o_axis_tvalid,
   input  logic                          i_axis_tready,
   output logic                          o_overflow,
   output logic                          o_geom_err,
   output logic [15:0]                   o_frame_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
   localparam int COL_W  = $clog2(H_ACTIVE + 1) + 1;
   localparam int LINE_W = $clog2(V_ACTIVE + 1) + 1;

   logic              vsync_lvl, vsync_edge, eol;
   logic              vsync_prev_q, vsync_prev_d;
   logic [1:0]        state_q, state_d;
   logic              hold_vld_q, hold_vld_d;
   logic [RGB_W-1:0]  hold_data_q, hold_data_d;
   logic              sof_pend_q, sof_pend_d;
   logic              overflow_q, overflow_d;
   logic              geom_err_q, geom_err_d;
   logic              frame_bad_q, frame_bad_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [COL_W-1:0]  col_cnt_q, col_cnt_d, col_inc;
   logic [LINE_W-1:0] line_cnt_q, line_cnt_d, line_inc;
   logic              wr_req, wr_en, rd_en, fifo_full, fifo_empty;
   logic [WORD_W-1:0] wr_word, rd_word;
   logic              unused_inputs;

   assign unused_inputs = ^{i_rgb_hsync, i_set_x, i_set_y};

   assign vsync_lvl  = (i_rgb_vsync == VSYNC_POL);
   assign vsync_edge = vsync_lvl && !vsync_prev_q;
   // Held pixel is end-of-line when the pixel following it is no longer active.
   assign eol        = !i_rgb_vde;
   assign wr_req     = hold_vld_q && (state_q == ST_ACTIVE);
   assign wr_en      = wr_req && !fifo_full;
   assign rd_en      = !fifo_empty && i_axis_tready;
   assign wr_word    = {sof_pend_q, eol, hold_data_q};
   assign col_inc    = (&col_cnt_q) ? col_cnt_q : col_cnt_q + 1'b1;
   assign line_inc   = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 1'b1;

   always_comb begin
      vsync_prev_d = vsync_lvl;
      state_d      = state_q;
      hold_vld_d   = 1'b0;
      hold_data_d  = hold_data_q;
      sof_pend_d   = sof_pend_q;
      overflow_d   = overflow_q;
      geom_err_d   = geom_err_q;
      frame_bad_d  = frame_bad_q;
      frame_cnt_d  = frame_cnt_q;
      col_cnt_d    = col_cnt_q;
      line_cnt_d   = line_cnt_q;

      if (wr_req && fifo_full) begin
         overflow_d = 1'b1;
         state_d    = ST_DROP;
      end

      if (wr_en) begin
         sof_pend_d = 1'b0;
         if (eol) begin
            if (col_inc != COL_W'(H_ACTIVE)) begin
               geom_err_d  = 1'b1;
               frame_bad_d = 1'b1;
            end
            col_cnt_d  = '0;
            line_cnt_d = line_inc;
         end else begin
            col_cnt_d = col_inc;
         end
      end

      // Frame boundary wins over pixel bookkeeping from the same cycle.
      if (vsync_edge) begin
         if (state_q == ST_ACTIVE) begin
            if (line_cnt_q != LINE_W'(V_ACTIVE)) geom_err_d = 1'b1;
            else if (!frame_bad_q)               frame_cnt_d = frame_cnt_q + 16'd1;
         end
         state_d     = ST_ACTIVE;
         sof_pend_d  = 1'b1;
         frame_bad_d = 1'b0;
         col_cnt_d   = '0;
         line_cnt_d  = '0;
      end

      if (i_rgb_vde && (vsync_edge || state_q == ST_ACTIVE)) begin
         hold_vld_d  = 1'b1;
         hold_data_d = i_rgb_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vsync_prev_q <= 1'b0;
         state_q      <= ST_WAIT_SOF;
         hold_vld_q   <= 1'b0;
         hold_data_q  <= '0;
         sof_pend_q   <= 1'b0;
         overflow_q   <= 1'b0;
         geom_err_q   <= 1'b0;
         frame_bad_q  <= 1'b0;
         frame_cnt_q  <= '0;
         col_cnt_q    <= '0;
         line_cnt_q   <= '0;
      end else begin
         vsync_prev_q <= vsync_prev_d;
         state_q      <= state_d;
         hold_vld_q   <= hold_vld_d;
         hold_data_q  <= hold_data_d;
         sof_pend_q   <= sof_pend_d;
         overflow_q   <= overflow_d;
         geom_err_q   <= geom_err_d;
         frame_bad_q  <= frame_bad_d;
         frame_cnt_q  <= frame_cnt_d;
         col_cnt_q    <= col_cnt_d;
         line_cnt_q   <= line_cnt_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (wr_en),
      .wr_data (wr_word),
      .full    (fifo_full),
      .rd_en   (rd_en),
      .rd_data (rd_word),
      .empty   (fifo_empty),
      .level   (o_fifo_level)
   );

   assign o_axis_tvalid = !fifo_empty;
   assign o_axis_tdata  = fifo_empty ? '0 : rd_word[RGB_W-1:0];
   assign o_axis_tlast  = !fifo_empty && rd_word[TLAST_BIT];
   assign o_axis_tuser  = !fifo_empty && rd_word[TUSER_BIT];
   assign o_overflow    = overflow_q;
   assign o_geom_err    = geom_err_q;
   assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_rgb_stream_to_axis.sv
// tb/tb_rgb_stream_to_axis.sv - scoreboard bench for rgb_stream_to_axis with a 4x2 frame and 16-deep FIFO
module tb_rgb_stream_to_axis;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] rgb_data;
   logic        hsync, vsync, vde;
   logic [10:0] set_x;
   logic [9:0]  set_y;
   logic [23:0] tdata;
   logic        tuser, tlast, tvalid, tready;
   logic        overflow, geom_err;
   logic [15:0] frame_cnt;
   logic [4:0]  level;

   int          errors = 0;
   int          checks = 0;
   logic [25:0] exp_q[$];
   logic [23:0] next_pix = 24'hA00000;
   bit          toggle_en = 1'b0;
   int          max_level = 0;
   bit          stall_seen = 1'b0;
   logic [25:0] held;

   always #5 clk = ~clk;

   rgb_stream_to_axis #(
      .H_ACTIVE   (4),
      .V_ACTIVE   (2),
      .FIFO_DEPTH (16),
      .VSYNC_POL  (1'b1)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_rgb_data    (rgb_data),
      .i_rgb_hsync   (hsync),
      .i_rgb_vsync   (vsync),
      .i_rgb_vde     (vde),
      .i_set_x       (set_x),
      .i_set_y       (set_y),
      .o_axis_tdata  (tdata),
      .o_axis_tuser  (tuser),
      .o_axis_tlast  (tlast),
      .o_axis_tvalid (tvalid),
      .i_axis_tready (tready),
      .o_overflow    (overflow),
      .o_geom_err    (geom_err),
      .o_frame_cnt   (frame_cnt),
      .o_fifo_level  (level)
   );

   // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
   always @(negedge clk) begin
      if (rst) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            checks++;
            if (!tvalid || {tuser, tlast, tdata} != held) begin
               errors++;
               $display("FAIL stall_hold got=%0b/%h exp=1/%h", tvalid, {tuser, tlast, tdata}, held);
            end
         end
         if (tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got=%h exp=none", {tuser, tlast, tdata});
            end else begin
               logic [25:0] e;
               e = exp_q.pop_front();
               if ({tuser, tlast, tdata} != e) begin
                  errors++;
                  $display("FAIL beat got=%h exp=%h", {tuser, tlast, tdata}, e);
               end
            end
         end
         stall_seen = tvalid && !tready;
         held       = {tuser, tlast, tdata};
         if (int'(level) > max_level) max_level = int'(level);
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (toggle_en) tready = !tready;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic vsync_pulse();
      vde   = 1'b0;
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      repeat (3) step();
   endtask

   // n pixels back to back; the first n_exp of them are expected on the stream.
   task automatic send_line(input int n, input bit sof, input int n_exp, input int gap);
      for (int i = 0; i < n; i++) begin
         rgb_data = next_pix;
         vde      = 1'b1;
         if (i < n_exp) exp_q.push_back({(sof && i == 0), (i == n - 1), next_pix});
         next_pix = next_pix + 24'd1;
         step();
      end
      vde      = 1'b0;
      rgb_data = '0;
      repeat (gap) step();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      chk({name, "_pending"}, exp_q.size(), 0);
      step();
      chk({name, "_level"}, level, 0);
   endtask

   initial begin
      rst      = 1'b1;
      rgb_data = '0;
      hsync    = 1'b0;
      vsync    = 1'b0;
      vde      = 1'b0;
      set_x    = '0;
      set_y    = '0;
      tready   = 1'b1;
      repeat (3) step();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_geom_err", geom_err, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_level", level, 0);
      rst = 1'b0;
      step();

      // Pixels before any vsync are discarded.
      send_line(4, 1'b0, 0, 3);
      send_line(4, 1'b0, 0, 3);
      chk("presof_level", level, 0);
      chk("presof_frame_cnt", frame_cnt, 0);

      // Good 4x2 frame.
      vsync_pulse();
      send_line(4, 1'b1, 4, 3);
      send_line(4, 1'b0, 4, 3);
      wait_drain("frame1");
      chk("frame1_cnt_before_edge", frame_cnt, 0);
      vsync_pulse();
      chk("frame1_cnt", frame_cnt, 1);
      chk("frame1_geom_err", geom_err, 0);

      // Short line: geometry error, frame not counted.
      send_line(3, 1'b1, 3, 3);
      chk("short_geom_err", geom_err, 1);
      send_line(4, 1'b0, 4, 3);
      wait_drain("short");
      vsync_pulse();
      chk("short_frame_cnt", frame_cnt, 1);

      // Ready toggling with 2-pixel lines.
      max_level = 0;
      toggle_en = 1'b1;
      send_line(2, 1'b1, 2, 2);
      for (int l = 0; l < 3; l++) send_line(2, 1'b0, 2, 2);
      wait_drain("toggle");
      toggle_en = 1'b0;
      tready    = 1'b1;
      checks++;
      if (max_level > 2) begin
         errors++;
         $display("FAIL toggle_max_level got=%0d exp<=2", max_level);
      end

      // Overflow: 20-pixel burst into 16-deep FIFO while stalled.
      vsync_pulse();
      chk("ovf_frame_cnt", frame_cnt, 1);
      tready = 1'b0;
      send_line(20, 1'b1, 16, 3);
      chk("ovf_level", level, 16);
      chk("ovf_flag", overflow, 1);
      chk("ovf_tvalid", tvalid, 1);
      send_line(4, 1'b0, 0, 3);
      chk("ovf_level_dropping", level, 16);
      tready = 1'b1;
      wait_drain("ovf");
      vsync_pulse();
      chk("resync_frame_cnt", frame_cnt, 1);
      send_line(4, 1'b1, 4, 3);
      send_line(4, 1'b0, 4, 3);
      wait_drain("resync");
      vsync_pulse();
      chk("resync_frame_cnt_after", frame_cnt, 2);
      chk("resync_overflow_sticky", overflow, 1);

      // Reset mid-line with 5 words queued.
      tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rgb_data = next_pix;
         vde      = 1'b1;
         next_pix = next_pix + 24'd1;
         step();
      end
      chk("midrst_level_pre", level, 5);
      exp_q.delete();
      rst = 1'b1;
      step();
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_level", level, 0);
      rst    = 1'b0;
      tready = 1'b1;
      send_line(4, 1'b0, 0, 3);
      send_line(4, 1'b0, 0, 3);
      chk("midrst_ignored_level", level, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      chk("midrst_overflow", overflow, 0);
      vsync_pulse();
      send_line(4, 1'b1, 4, 3);
      wait_drain("postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
